// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter for the single register-file write port, plus the per-register
// busy scoreboard used by issue for RAW hazard stalls.
module rf_wb_arbiter #(
  parameter  int NUM_REQ = 2,
  parameter  int REG_AMT = 16,
  parameter  int ADDR_W  = $clog2(REG_AMT),
  parameter  int DATA_W  = 8,
  localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_dst,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      rf_wr_en,
  output logic [ADDR_W-1:0]         rf_dst,
  output logic [DATA_W-1:0]         rf_datain,
  input  logic                      reserve_valid,
  input  logic [ADDR_W-1:0]         reserve_dst,
  output logic                      reserve_ok,
  output logic [REG_AMT-1:0]        busy,
  output logic [PTR_W-1:0]          dbg_rr_ptr
);

  // Handshake: a requester holds valid/dst/data stable until it sees ready; the
  // transfer happens on the edge where valid && ready, and ready is one-hot.

  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               rf_wr_en_q, rf_wr_en_d;
  logic [ADDR_W-1:0]  rf_dst_q, rf_dst_d;
  logic [DATA_W-1:0]  rf_datain_q, rf_datain_d;
  logic [REG_AMT-1:0] busy_q, busy_d;

  logic               grant_any;
  logic [PTR_W-1:0]   grant_idx;
  logic [ADDR_W-1:0]  sel_dst;
  logic [DATA_W-1:0]  sel_data;

  // Two passes give the rotating priority: first from rr_ptr upward, then wrap.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_any && req_valid[i] && (i >= int'(rr_ptr_q))) begin
        grant_any = 1'b1;
        grant_idx = PTR_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_any && req_valid[i] && (i < int'(rr_ptr_q))) begin
        grant_any = 1'b1;
        grant_idx = PTR_W'(i);
      end
    end
    if (reset) begin
      grant_any = 1'b0;
    end
  end

  always_comb begin
    req_ready = '0;
    sel_dst   = '0;
    sel_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_any && (PTR_W'(i) == grant_idx)) begin
        req_ready[i] = 1'b1;
        sel_dst      = req_dst[i*ADDR_W +: ADDR_W];
        sel_data     = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign reserve_ok = reserve_valid && !busy_q[reserve_dst] && !reset;

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    rf_wr_en_d  = grant_any;
    rf_dst_d    = rf_dst_q;
    rf_datain_d = rf_datain_q;
    if (grant_any) begin
      rr_ptr_d    = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
      rf_dst_d    = sel_dst;
      rf_datain_d = sel_data;
    end
  end

  // Clear before set so a same-register collision leaves the new producer owning it.
  always_comb begin
    busy_d = busy_q;
    if (rf_wr_en_q) begin
      busy_d[rf_dst_q] = 1'b0;
    end
    if (reserve_ok) begin
      busy_d[reserve_dst] = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr_q    <= '0;
      rf_wr_en_q  <= 1'b0;
      rf_dst_q    <= '0;
      rf_datain_q <= '0;
      busy_q      <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      rf_wr_en_q  <= rf_wr_en_d;
      rf_dst_q    <= rf_dst_d;
      rf_datain_q <= rf_datain_d;
      busy_q      <= busy_d;
    end
  end

  assign rf_wr_en   = rf_wr_en_q;
  assign rf_dst     = rf_dst_q;
  assign rf_datain  = rf_datain_q;
  assign busy       = busy_q;
  assign dbg_rr_ptr = rr_ptr_q;

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Owns the single write port of the register file.
- Round-robin arbitrates NUM_REQ writeback requesters (ALU, load, etc.) onto one registered write (wr_en/dst/datain).
- Keeps a per-register busy scoreboard: issue logic reserves a destination, and the matching commit clears it. Consumers use the scoreboard for RAW hazard stalls.
- Sits between the execution units and the register file, next to the issue stage.

Parameters:
- NUM_REQ, 2, number of writeback requesters (1..8).
- REG_AMT, 16, number of architectural registers; equals `REG_AMT.
- ADDR_W, $clog2(REG_AMT), register address width (t_RFadrs).
- DATA_W, 8, data width (t_data).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester write request.
- req_dst  in  NUM_REQ x ADDR_W  per-requester destination register.
- req_data  in  NUM_REQ x DATA_W  per-requester write data.
- req_ready  out  NUM_REQ  one-hot grant; request is consumed on valid&&ready.
- rf_wr_en  out  1  register-file write enable (registered).
- rf_dst  out  ADDR_W  register-file write address (registered).
- rf_datain  out  DATA_W  register-file write data (registered).
- reserve_valid  in  1  issue stage requests ownership of a destination.
- reserve_dst  in  ADDR_W  register to reserve.
- reserve_ok  out  1  combinational: reservation accepted this cycle.
- busy  out  REG_AMT  scoreboard; bit r=1 means a write to r is outstanding.

Behaviour:
- Reset is synchronous and active-high. While reset=1, at the edge:
  - rf_wr_en=0, rf_dst=0, rf_datain=0.
  - busy=0, rr_ptr=0.
  - req_ready=0 and reserve_ok=0 (combinational outputs are forced low during reset).
- Reset mid-operation drops any staged write: rf_wr_en=0 in the following cycle. All reservations are lost.
- Arbitration (combinational):
  - Grant the first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - req_ready is one-hot, or all zero if no request is valid.
  - At most one grant per cycle.
  - req_ready never asserts for a requester whose valid=0.
- Pointer: on a grant to i, rr_ptr <= (i+1) mod NUM_REQ. With no grant, rr_ptr holds.
- Requester rule: req_valid, req_dst and req_data are held stable until req_ready. A requester must not withdraw valid before it is granted. This is a bench assertion.
- Fairness: a continuously valid requester is granted within NUM_REQ cycles.
- Write pipeline: grant in cycle N gives rf_wr_en=1 in cycle N+1, with rf_dst/rf_datain equal to the granted dst/data.
  - The register file captures the write at the end of N+1.
  - The data is readable from cycle N+2.
  - Back-to-back grants give rf_wr_en=1 on consecutive cycles, for full throughput.
  - With no grant in cycle N, rf_wr_en=0 in N+1. rf_dst and rf_datain hold their previous values.
- Scoreboard:
  - reserve_ok = reserve_valid && !busy[reserve_dst] && !reset.
  - Accepted reservation: busy[reserve_dst] <= 1.
  - Commit: when rf_wr_en=1, busy[rf_dst] <= 0 at the same edge the register file writes. busy therefore drops in cycle N+2, aligned with data visibility.
  - Clearing a non-busy register is a no-op. Unreserved writes are legal.
  - If set and clear target the same register in the same cycle, set wins: the new producer owns it and busy stays 1.
  - A rejected reservation (busy=1) leaves state unchanged. Issue must retry.
- NUM_REQ=1 degenerates to: req_ready = req_valid, with no arbitration.

Test Plan:
- Reset: hold reset 2 cycles with all inputs active -> rf_wr_en=0, busy=0, req_ready=0, reserve_ok=0. Release -> first grant goes to requester 0.
- Single write: req_valid[1]=1, dst=5, data=8'hA7 in cycle 3 -> req_ready[1]=1 in cycle 3. Cycle 4: rf_wr_en=1, rf_dst=5, rf_datain=8'hA7. Cycle 5: rf_wr_en=0.
- Round-robin: both requesters valid continuously (req0 dst=1/data=8'h11, req1 dst=2/data=8'h22) -> grants alternate 0,1,0,1. rf_wr_en=1 every cycle, rf_dst alternating 1,2.
- Scoreboard hazard: reserve r3 in cycle 0 -> reserve_ok=1, busy[3]=1 from cycle 1. Re-reserve r3 in cycle 2 -> reserve_ok=0. Write to r3 granted in cycle 4 -> busy[3]=1 in cycles 4-5, busy[3]=0 in cycle 6.
- Set/clear collision: r7 not busy, write to r7 committing (rf_wr_en=1, rf_dst=7) while reserve_dst=7 is accepted -> busy[7]=1 afterwards.
- Reset mid-flight: grant in cycle N, reset=1 in cycle N+1 -> rf_wr_en=0 in cycle N+2 (suppressed), busy=0, rr_ptr=0.
